// File: rtl/crc8_pkg.sv
// Shared CRC8 definitions (poly 8'h2F, init 8'hFF, MSB-first serial update)
// used by the serial CRC8 generator and checker.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h2F;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } chk_state_e;

  // One serial LFSR step: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [7:0] crc8_new(input logic [7:0] crc8_old, input logic data);
    logic fb;
    fb       = crc8_old[7] ^ data;
    crc8_new = {crc8_old[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial_chk.sv
// Serial CRC8 frame checker: deserializes payload + 8 CRC bits, flags pass/fail,
// and reports frames aborted by a restart or an inter-bit timeout.
module crc8_serial_chk
  import crc8_pkg::*;
#(
  parameter int DATA_BITS = 16,
  parameter int TMO_CYC   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vld,
  input  logic                 i_data,
  input  logic                 i_sof,
  input  logic                 i_cnt_clr,
  output logic                 o_frm_vld,
  output logic [DATA_BITS-1:0] o_frm_data,
  output logic                 o_crc_ok,
  output logic                 o_crc_err,
  output logic                 o_abort,
  output logic [7:0]           o_err_cnt
);

  localparam logic [6:0]  LAST_DATA = 7'(DATA_BITS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TMO_CYC - 1);

  chk_state_e           state_q, state_d;
  logic [7:0]           crc_q, crc_d;
  logic [7:0]           rx_crc_q, rx_crc_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [6:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]          tmo_q, tmo_d;
  logic                 frm_vld_q, frm_vld_d;
  logic [DATA_BITS-1:0] frm_data_q, frm_data_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 crc_err_q, crc_err_d;
  logic                 abort_q, abort_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 start_s;
  logic                 in_frame_s;

  // Next-state logic for the frame FSM, LFSR, shift registers and result pulses.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    rx_crc_d   = rx_crc_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    frm_vld_d  = 1'b0;
    frm_data_d = frm_data_q;
    crc_ok_d   = 1'b0;
    crc_err_d  = 1'b0;
    abort_d    = 1'b0;
    start_s    = i_vld & i_sof;
    in_frame_s = (state_q == DATA) || (state_q == CRC);

    // A start bit always opens a new frame, aborting any frame in progress,
    // including one whose final CRC bit carries the start flag.
    if (start_s) begin
      abort_d = in_frame_s;
      crc_d   = crc8_new(CRC8_INIT, i_data);
      shreg_d = DATA_BITS'(i_data);
      tmo_d   = 16'd0;
      if (DATA_BITS == 1) begin
        state_d   = CRC;
        bit_cnt_d = 7'd0;
      end else begin
        state_d   = DATA;
        bit_cnt_d = 7'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          tmo_d = 16'd0;
        end
        DATA, CRC: begin
          if (i_vld) begin
            tmo_d = 16'd0;
            if (state_q == DATA) begin
              shreg_d = (shreg_q << 1'b1) | DATA_BITS'(i_data);
              crc_d   = crc8_new(crc_q, i_data);
              if (bit_cnt_q == LAST_DATA) begin
                state_d   = CRC;
                bit_cnt_d = 7'd0;
              end else begin
                bit_cnt_d = bit_cnt_q + 7'd1;
              end
            end else begin
              rx_crc_d = {rx_crc_q[6:0], i_data};
              if (bit_cnt_q == 7'd7) begin
                state_d    = IDLE;
                bit_cnt_d  = 7'd0;
                frm_vld_d  = 1'b1;
                frm_data_d = shreg_q;
                crc_ok_d   = (rx_crc_d == crc_q);
                crc_err_d  = (rx_crc_d != crc_q);
              end else begin
                bit_cnt_d = bit_cnt_q + 7'd1;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = 7'd0;
            tmo_d     = 16'd0;
            abort_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = 7'd0;
          tmo_d     = 16'd0;
        end
      endcase
    end
  end

  // Error counter: clear wins, otherwise count each error/abort pulse, saturating.
  always_comb begin
    if (i_cnt_clr) begin
      err_cnt_d = 8'h00;
    end else if ((crc_err_d | abort_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      crc_q      <= CRC8_INIT;
      rx_crc_q   <= 8'h00;
      shreg_q    <= '0;
      bit_cnt_q  <= 7'd0;
      tmo_q      <= 16'd0;
      frm_vld_q  <= 1'b0;
      frm_data_q <= '0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
      abort_q    <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      rx_crc_q   <= rx_crc_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      frm_vld_q  <= frm_vld_d;
      frm_data_q <= frm_data_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
      abort_q    <= abort_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_frm_vld  = frm_vld_q;
  assign o_frm_data = frm_data_q;
  assign o_crc_ok   = crc_ok_q;
  assign o_crc_err  = crc_err_q;
  assign o_abort    = abort_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_crc8_serial_chk.sv
// Directed bench for crc8_serial_chk; expected CRCs hand-computed
// (16'h0000 -> 8'hB8, 16'hFFFF -> 8'h42 for init 8'hFF, poly 8'h2F).
module tb_crc8_serial_chk;

  logic        i_clk;
  logic        i_rst;
  logic        i_vld;
  logic        i_data;
  logic        i_sof;
  logic        i_cnt_clr;
  logic        o_frm_vld;
  logic [15:0] o_frm_data;
  logic        o_crc_ok;
  logic        o_crc_err;
  logic        o_abort;
  logic [7:0]  o_err_cnt;
  logic        t_frm_vld;
  logic [15:0] t_frm_data;
  logic        t_crc_ok;
  logic        t_crc_err;
  logic        t_abort;
  logic [7:0]  t_err_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int vld_cnt = 0, abort_cnt = 0, t_vld_cnt = 0, t_abort_cnt = 0;

  crc8_serial_chk #(.DATA_BITS(16), .TMO_CYC(255)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_data(i_data), .i_sof(i_sof),
    .i_cnt_clr(i_cnt_clr), .o_frm_vld(o_frm_vld), .o_frm_data(o_frm_data),
    .o_crc_ok(o_crc_ok), .o_crc_err(o_crc_err), .o_abort(o_abort), .o_err_cnt(o_err_cnt)
  );

  crc8_serial_chk #(.DATA_BITS(16), .TMO_CYC(4)) dut_t (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_data(i_data), .i_sof(i_sof),
    .i_cnt_clr(i_cnt_clr), .o_frm_vld(t_frm_vld), .o_frm_data(t_frm_data),
    .o_crc_ok(t_crc_ok), .o_crc_err(t_crc_err), .o_abort(t_abort), .o_err_cnt(t_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_frm_vld) vld_cnt     <= vld_cnt + 1;
    if (o_abort)   abort_cnt   <= abort_cnt + 1;
    if (t_frm_vld) t_vld_cnt   <= t_vld_cnt + 1;
    if (t_abort)   t_abort_cnt <= t_abort_cnt + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic sof, input logic d, input int gmin, input int gmax);
    int gap;
    gap = $urandom_range(gmax, gmin);
    for (int g = 0; g < gap; g++) tick();
    i_vld  = 1'b1;
    i_sof  = sof;
    i_data = d;
    tick();
    i_vld  = 1'b0;
    i_sof  = 1'b0;
    i_data = 1'b0;
  endtask

  task automatic send_payload(input logic [15:0] data, input int hi, input int gmin, input int gmax);
    for (int i = hi; i >= 0; i--) send_bit(1'b0, data[i], gmin, gmax);
  endtask

  task automatic send_crc_bits(input logic [7:0] c, input int hi, input int lo,
                               input int gmin, input int gmax);
    for (int i = hi; i >= lo; i--) send_bit(1'b0, c[i], gmin, gmax);
  endtask

  task automatic send_frame(input logic [15:0] data, input logic [7:0] c,
                            input int gmin, input int gmax);
    send_bit(1'b1, data[15], gmin, gmax);
    send_payload(data, 14, gmin, gmax);
    send_crc_bits(c, 7, 0, gmin, gmax);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    int ab;
    i_vld = 1'b1; i_sof = 1'b1; i_data = 1'b1; i_cnt_clr = 1'b0;
    do_reset();
    i_vld = 1'b0; i_sof = 1'b0; i_data = 1'b0;
    chk_cnt++; if (o_frm_vld !== 1'b0) $display("FAIL rst_frm_vld: got %b want 0", o_frm_vld); else pass_cnt++;
    chk_cnt++; if (o_frm_data !== 16'h0000) $display("FAIL rst_frm_data: got %h want 0000", o_frm_data); else pass_cnt++;
    chk_cnt++; if (o_crc_ok !== 1'b0) $display("FAIL rst_crc_ok: got %b want 0", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (o_crc_err !== 1'b0) $display("FAIL rst_crc_err: got %b want 0", o_crc_err); else pass_cnt++;
    chk_cnt++; if (o_abort !== 1'b0) $display("FAIL rst_abort: got %b want 0", o_abort); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h00) $display("FAIL rst_err_cnt: got %h want 00", o_err_cnt); else pass_cnt++;
    // Reset in the middle of a frame discards it silently.
    send_bit(1'b1, 1'b1, 0, 0);
    send_payload(16'hFFFF, 14, 10, 0);
    ab = abort_cnt;
    do_reset();
    tick();
    chk_cnt++; if (abort_cnt - ab !== 0) $display("FAIL rst_mid_abort: got %0d pulses want 0", abort_cnt - ab); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h00) $display("FAIL rst_mid_err_cnt: got %h want 00", o_err_cnt); else pass_cnt++;
  endtask

  task automatic test_good_zero();
    int vb;
    do_reset();
    vb = vld_cnt;
    send_bit(1'b1, 1'b0, 0, 0);
    send_payload(16'h0000, 14, 0, 0);
    send_crc_bits(8'hB8, 7, 1, 0, 0);
    chk_cnt++; if (o_frm_vld !== 1'b0) $display("FAIL zero_early_vld: got %b want 0", o_frm_vld); else pass_cnt++;
    send_crc_bits(8'hB8, 0, 0, 0, 0);
    chk_cnt++; if (o_frm_vld !== 1'b1) $display("FAIL zero_vld: got %b want 1", o_frm_vld); else pass_cnt++;
    chk_cnt++; if (o_frm_data !== 16'h0000) $display("FAIL zero_data: got %h want 0000", o_frm_data); else pass_cnt++;
    chk_cnt++; if (o_crc_ok !== 1'b1) $display("FAIL zero_ok: got %b want 1", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (o_crc_err !== 1'b0) $display("FAIL zero_err: got %b want 0", o_crc_err); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h00) $display("FAIL zero_err_cnt: got %h want 00", o_err_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (o_frm_vld !== 1'b0) $display("FAIL zero_vld_width: got %b want 0", o_frm_vld); else pass_cnt++;
    chk_cnt++; if (o_crc_ok !== 1'b0) $display("FAIL zero_ok_idle: got %b want 0", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (vld_cnt - vb !== 1) $display("FAIL zero_vld_count: got %0d want 1", vld_cnt - vb); else pass_cnt++;
  endtask

  task automatic test_gaps();
    do_reset();
    send_frame(16'hFFFF, 8'h42, 0, 5);
    chk_cnt++; if (o_frm_vld !== 1'b1) $display("FAIL gaps_vld: got %b want 1", o_frm_vld); else pass_cnt++;
    chk_cnt++; if (o_crc_ok !== 1'b1) $display("FAIL gaps_ok: got %b want 1", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (o_frm_data !== 16'hFFFF) $display("FAIL gaps_data: got %h want ffff", o_frm_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (o_frm_data !== 16'hFFFF) $display("FAIL gaps_data_hold: got %h want ffff", o_frm_data); else pass_cnt++;
  endtask

  task automatic test_bad_crc();
    do_reset();
    send_frame(16'h0000, 8'hB9, 0, 0);
    chk_cnt++; if (o_frm_vld !== 1'b1) $display("FAIL bad_vld: got %b want 1", o_frm_vld); else pass_cnt++;
    chk_cnt++; if (o_crc_err !== 1'b1) $display("FAIL bad_err: got %b want 1", o_crc_err); else pass_cnt++;
    chk_cnt++; if (o_crc_ok !== 1'b0) $display("FAIL bad_ok: got %b want 0", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h01) $display("FAIL bad_err_cnt: got %h want 01", o_err_cnt); else pass_cnt++;
  endtask

  task automatic test_restart();
    int vb, ab;
    do_reset();
    vb = vld_cnt; ab = abort_cnt;
    send_bit(1'b1, 1'b0, 0, 0);
    send_payload(16'h5555, 14, 7, 0);
    send_bit(1'b1, 1'b1, 0, 0);
    chk_cnt++; if (o_abort !== 1'b1) $display("FAIL rst_sof_abort: got %b want 1", o_abort); else pass_cnt++;
    send_payload(16'hFFFF, 14, 0, 0);
    send_crc_bits(8'h42, 7, 0, 0, 0);
    chk_cnt++; if (o_crc_ok !== 1'b1) $display("FAIL restart_ok: got %b want 1", o_crc_ok); else pass_cnt++;
    chk_cnt++; if (o_frm_data !== 16'hFFFF) $display("FAIL restart_data: got %h want ffff", o_frm_data); else pass_cnt++;
    tick();
    chk_cnt++; if (vld_cnt - vb !== 1) $display("FAIL restart_vld_count: got %0d want 1", vld_cnt - vb); else pass_cnt++;
    chk_cnt++; if (abort_cnt - ab !== 1) $display("FAIL restart_abort_count: got %0d want 1", abort_cnt - ab); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h01) $display("FAIL restart_err_cnt: got %h want 01", o_err_cnt); else pass_cnt++;
  endtask

  task automatic test_sof_last_crc();
    int vb, ab;
    do_reset();
    vb = vld_cnt; ab = abort_cnt;
    send_bit(1'b1, 1'b0, 0, 0);
    send_payload(16'h0000, 14, 0, 0);
    send_crc_bits(8'hB8, 7, 1, 0, 0);
    send_bit(1'b1, 1'b0, 0, 0);
    chk_cnt++; if (o_abort !== 1'b1) $display("FAIL lastsof_abort: got %b want 1", o_abort); else pass_cnt++;
    chk_cnt++; if (o_frm_vld !== 1'b0) $display("FAIL lastsof_vld: got %b want 0", o_frm_vld); else pass_cnt++;
    send_payload(16'h0000, 14, 0, 0);
    send_crc_bits(8'hB8, 7, 0, 0, 0);
    chk_cnt++; if (o_crc_ok !== 1'b1) $display("FAIL lastsof_ok: got %b want 1", o_crc_ok); else pass_cnt++;
    tick();
    chk_cnt++; if (vld_cnt - vb !== 1) $display("FAIL lastsof_vld_count: got %0d want 1", vld_cnt - vb); else pass_cnt++;
    chk_cnt++; if (abort_cnt - ab !== 1) $display("FAIL lastsof_abort_count: got %0d want 1", abort_cnt - ab); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h01) $display("FAIL lastsof_err_cnt: got %h want 01", o_err_cnt); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int vb, ab;
    do_reset();
    vb = t_vld_cnt; ab = t_abort_cnt;
    send_bit(1'b1, 1'b0, 0, 0);
    send_payload(16'h0000, 14, 0, 0);
    send_crc_bits(8'hB8, 7, 5, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (t_abort_cnt - ab !== 0) $display("FAIL tmo_early: got %0d pulses want 0", t_abort_cnt - ab); else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    chk_cnt++; if (t_abort_cnt - ab !== 1) $display("FAIL tmo_abort: got %0d pulses want 1", t_abort_cnt - ab); else pass_cnt++;
    chk_cnt++; if (t_err_cnt !== 8'h01) $display("FAIL tmo_err_cnt: got %h want 01", t_err_cnt); else pass_cnt++;
    send_crc_bits(8'hB8, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (t_vld_cnt - vb !== 0) $display("FAIL tmo_no_vld: got %0d pulses want 0", t_vld_cnt - vb); else pass_cnt++;
    // Gaps of 3 idle cycles stay just below the 4-cycle limit.
    send_frame(16'h0000, 8'hB8, 3, 3);
    chk_cnt++; if (t_frm_vld !== 1'b1) $display("FAIL tmo_gap3_vld: got %b want 1", t_frm_vld); else pass_cnt++;
    chk_cnt++; if (t_crc_ok !== 1'b1 || t_crc_err !== 1'b0) $display("FAIL tmo_gap3_ok: got ok=%b err=%b want ok=1 err=0", t_crc_ok, t_crc_err); else pass_cnt++;
    chk_cnt++; if (t_frm_data !== 16'h0000) $display("FAIL tmo_gap3_data: got %h want 0000", t_frm_data); else pass_cnt++;
    chk_cnt++; if (t_abort_cnt - ab !== 1) $display("FAIL tmo_gap3_abort: got %0d pulses want 1", t_abort_cnt - ab); else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int n = 0; n < 254; n++) send_frame(16'h0000, 8'hB9, 0, 0);
    tick();
    chk_cnt++; if (o_err_cnt !== 8'hFE) $display("FAIL sat_254: got %h want fe", o_err_cnt); else pass_cnt++;
    send_frame(16'h0000, 8'hB9, 0, 0);
    chk_cnt++; if (o_err_cnt !== 8'hFF) $display("FAIL sat_255: got %h want ff", o_err_cnt); else pass_cnt++;
    for (int n = 0; n < 45; n++) send_frame(16'h0000, 8'hB9, 0, 0);
    chk_cnt++; if (o_err_cnt !== 8'hFF) $display("FAIL sat_300: got %h want ff", o_err_cnt); else pass_cnt++;
    i_cnt_clr = 1'b1;
    send_frame(16'h0000, 8'hB9, 0, 0);
    chk_cnt++; if (o_crc_err !== 1'b1) $display("FAIL sat_301_err: got %b want 1", o_crc_err); else pass_cnt++;
    chk_cnt++; if (o_err_cnt !== 8'h00) $display("FAIL sat_clr: got %h want 00", o_err_cnt); else pass_cnt++;
    tick();
    i_cnt_clr = 1'b0;
    tick();
    chk_cnt++; if (o_err_cnt !== 8'h00) $display("FAIL sat_clr_hold: got %h want 00", o_err_cnt); else pass_cnt++;
  endtask

  initial begin
    i_rst = 1'b0; i_vld = 1'b0; i_data = 1'b0; i_sof = 1'b0; i_cnt_clr = 1'b0;
    test_reset();
    test_good_zero();
    test_gaps();
    test_bad_crc();
    test_restart();
    test_sof_last_crc();
    test_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
